spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2: clk cycles per sck half-period; legal values are 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a transfer request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-006 The block SHALL have port req_data, input, 16 bits: transmit bits, right-aligned, sent MSB-first.
REQ-007 The block SHALL have port req_len, input, 4 bits: bit count N; 1..15 literal, 0 means 16.
REQ-008 The block SHALL have port resp_valid, output, 1 bit: one-cycle pulse, received data valid.
REQ-009 The block SHALL have port resp_data, output, 16 bits: received bits, right-aligned, upper (16-N) bits zero.
REQ-010 The block SHALL have port sck, output, 1 bit: SPI clock, mode 0, idle low.
REQ-011 The block SHALL have port ss_n, output, 1 bit: slave select, active-low.
REQ-012 The block SHALL have port mosi, output, 1 bit: master-out data.
REQ-013 The block SHALL have port miso, input, 1 bit: master-in data, driven by the downstream SPI slave on sck rising edges.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SETUP, LOW, HIGH and HOLD.
REQ-015 In IDLE the block SHALL drive req_ready=1, ss_n=1, sck=0 and mosi=1; req_ready SHALL be 0 in every other state.
REQ-016 The block SHALL accept a request only on a clk edge where req_valid && req_ready holds.
REQ-017 On accept the block SHALL latch tx_shift = req_data << (16-N), clear rx_shift, load the bit counter with N and enter SETUP.
REQ-018 On accept the block SHALL also drive ss_n=0 and mosi=tx_shift[15] from the next cycle.
REQ-019 SETUP, LOW, HIGH and HOLD SHALL each last exactly CLK_DIV clk cycles, counted by a phase counter that reloads on every state change.
REQ-020 At the end of SETUP or LOW the block SHALL, on the same edge: set sck=1, shift rx_shift <= {rx_shift[14:0], miso}, decrement the bit counter and enter HIGH.
REQ-021 miso SHALL be sampled from its value immediately before the sck rising edge, which is the value the slave drove on the previous rising edge.
REQ-022 At the end of HIGH with bits remaining, the block SHALL set sck=0, shift tx_shift left by 1, drive mosi=new tx_shift[15] and enter LOW.
REQ-023 At the end of HIGH with the bit counter at 0, the block SHALL set sck=0, keep ss_n=0 and enter HOLD.
REQ-024 At the end of HOLD the block SHALL set ss_n=1 and mosi=1, pulse resp_valid=1 for exactly one cycle with resp_data = rx_shift, and enter IDLE.
REQ-025 resp_data SHALL hold its value until the next resp_valid pulse.
REQ-026 Latency SHALL be fixed: for accept on edge E, resp_valid and ss_n=1 appear after edge E + CLK_DIV*(2N+1).
REQ-027 A transfer SHALL produce exactly N sck rising edges.
REQ-028 req_valid while busy SHALL be ignored; req_data and req_len changes after accept SHALL have no effect.
REQ-029 There is no resp_ready: a back-to-back request SHALL be accepted in the same cycle resp_valid is high, because the block is already in IDLE.
REQ-030 req_len=0 SHALL run a 16-bit transfer; req_len=1 SHALL run 1 sck pulse, taking SETUP, HIGH, HOLD = 3*CLK_DIV cycles.
REQ-031 The phase counter width SHALL be 8 bits, and the bit counter SHALL be 5 bits with no wrap-around.

Reset
REQ-032 When rst_n=0 at a clk edge, the block SHALL enter IDLE from any state, including mid-transfer.
REQ-033 Reset SHALL set sck=0, ss_n=1, mosi=1, req_ready=1, resp_valid=0, resp_data=0 and clear all counters and shift registers.
REQ-034 A transfer aborted by reset SHALL produce no resp_valid.

Verification
REQ-035 Loopback (miso=mosi), CLK_DIV=2, req_data=0x00A5, req_len=8 -> 8 sck pulses, mosi sequence 1,0,1,0,0,1,0,1, resp_valid 34 cycles after accept, resp_data=0x00A5.
REQ-036 miso tied 1, req_len=0, req_data=0x1234 -> 16 sck pulses, resp_data=0xFFFF; miso tied 0 with req_len=3 -> resp_data=0x0000.
REQ-037 Behavioural mode-0 slave returning 0x3C on the last 8 of 16 bits, req_data=0xC300, req_len=0 -> resp_data[7:0]=0x3C and ss_n high for the whole idle period.
REQ-038 req_valid held high continuously, CLK_DIV=1, req_len=1 -> a new accept every 4 cycles (3 busy + 1 IDLE/resp cycle), one resp_valid per accept, req_ready=0 while busy.
REQ-039 rst_n=0 for 1 cycle after the 3rd sck rise of an 8-bit transfer -> next cycle sck=0, ss_n=1, mosi=1, no resp_valid; a following request completes normally.
REQ-040 req_data and req_len changed while busy -> resp_data and the sck count reflect only the accepted request.

Source files
------------

// File: rtl/spi_master.sv
// Mode-0 SPI master: one request moves 1..16 bits MSB-first and returns the
// received bits right-aligned after a fixed latency of CLK_DIV*(2N+1) cycles.
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [3:0]  req_len,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        sck,
  output logic        ss_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StHold
  } state_e;

  localparam logic [7:0] PhaseLast = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;

  logic [4:0]  req_bits;
  logic [15:0] tx_load;
  logic        phase_done;

  // A length of 0 encodes a full 16-bit transfer.
  assign req_bits   = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
  assign tx_load    = req_data << (5'd16 - req_bits);
  assign phase_done = (phase_q == 8'd0);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bits_d       = bits_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    sck_d        = sck_q;
    ss_n_d       = ss_n_q;
    mosi_d       = mosi_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          tx_d    = tx_load;
          rx_d    = 16'h0000;
          bits_d  = req_bits;
          phase_d = PhaseLast;
          ss_n_d  = 1'b0;
          mosi_d  = tx_load[15];
          ready_d = 1'b0;
          state_d = StSetup;
        end
      end

      StSetup, StLow: begin
        if (phase_done) begin
          // miso still holds the bit the slave drove on the previous sck rise.
          sck_d   = 1'b1;
          rx_d    = {rx_q[14:0], miso};
          bits_d  = (bits_q != 5'd0) ? bits_q - 5'd1 : bits_q;
          phase_d = PhaseLast;
          state_d = StHigh;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      StHigh: begin
        if (phase_done) begin
          sck_d   = 1'b0;
          phase_d = PhaseLast;
          if (bits_q == 5'd0) begin
            state_d = StHold;
          end else begin
            // Rotate rather than shift: only the top N bits are ever sent.
            tx_d    = {tx_q[14:0], tx_q[15]};
            mosi_d  = tx_q[14];
            state_d = StLow;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      StHold: begin
        if (phase_done) begin
          ss_n_d       = 1'b1;
          mosi_d       = 1'b1;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = rx_q;
          state_d      = StIdle;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      default: begin
        sck_d   = 1'b0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b1;
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= 8'd0;
      bits_q       <= 5'd0;
      tx_q         <= 16'h0000;
      rx_q         <= 16'h0000;
      sck_q        <= 1'b0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b1;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bits_q       <= bits_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      sck_q        <= sck_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss_n       = ss_n_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and 1) share stimulus; each is checked
// every cycle against a timeline model derived from the transfer's segment arithmetic.
module tb_spi_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_len;
  logic        loop_mode;
  logic [15:0] sl_word;

  int checks;
  int failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Div = (g == 0) ? 2 : 1;

    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        slave_miso;

    assign miso = loop_mode ? mosi : slave_miso;

    spi_master #(.CLK_DIV(Div)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_len   (req_len),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso)
    );

    // Mode-0 slave: presents sl_word[15] on select, next bit after each sck rise.
    initial begin
      int   idx;
      logic sck_p;
      logic ss_p;
      idx        = 15;
      slave_miso = 1'b0;
      sck_p      = 1'b0;
      ss_p       = 1'b1;
      forever begin
        @(sck or ss_n);
        if (ss_p === 1'b1 && ss_n === 1'b0) begin
          idx        = 15;
          slave_miso = sl_word[15];
        end else if (sck_p === 1'b0 && sck === 1'b1 && idx > 0) begin
          idx--;
          slave_miso = sl_word[idx];
        end
        sck_p = sck;
        ss_p  = ss_n;
      end
    end

    // Reference model: elapsed cycles since accept fully determine the outputs.
    int          c;
    int          mn;
    logic        m_busy;
    logic        m_rv;
    logic        started;
    logic [15:0] m_data;
    logic [15:0] m_exp;
    logic [15:0] m_rd;

    initial begin
      m_busy  = 1'b0;
      m_rv    = 1'b0;
      m_rd    = 16'h0;
      m_data  = 16'h0;
      m_exp   = 16'h0;
      c       = 0;
      mn      = 1;
      started = 1'b0;
      forever begin
        @(posedge clk);
        started = 1'b1;
        if (!rst_n) begin
          m_busy = 1'b0;
          m_rv   = 1'b0;
          m_rd   = 16'h0;
        end else if (!m_busy) begin
          m_rv = 1'b0;
          if (req_valid) begin
            m_busy = 1'b1;
            c      = 0;
            mn     = (req_len == 4'd0) ? 16 : int'(req_len);
            m_data = req_data;
            if (loop_mode) m_exp = 16'(int'(req_data) & ((1 << mn) - 1));
            else           m_exp = 16'(int'(sl_word) >> (16 - mn));
          end
        end else begin
          m_rv = 1'b0;
          c++;
          if (c == int'(Div) * (2 * mn + 1)) begin
            m_busy = 1'b0;
            m_rv   = 1'b1;
            m_rd   = m_exp;
          end
        end
      end
    end

    int          ncyc;
    int          acc_cyc;
    int          last_acc;
    int          lat;
    int          gap;
    int          rises;
    logic [15:0] mosi_seq;

    initial begin
      logic e_rr, e_ss, e_sck, e_mosi;
      logic p_ready, p_sck;
      int   s, b;
      ncyc     = 0;
      acc_cyc  = 0;
      last_acc = -100;
      lat      = -1;
      gap      = -1;
      rises    = 0;
      mosi_seq = 16'h0;
      p_ready  = 1'b0;
      p_sck    = 1'b0;
      forever begin
        @(negedge clk);
        if (started) begin
          ncyc++;
          if (m_busy) begin
            s      = c / int'(Div);
            e_rr   = 1'b0;
            e_ss   = 1'b0;
            e_sck  = (s % 2) == 1;
            b      = (s >= 2 * mn) ? mn - 1 : s / 2;
            e_mosi = m_data[mn-1-b];
          end else begin
            e_rr   = 1'b1;
            e_ss   = 1'b1;
            e_sck  = 1'b0;
            e_mosi = 1'b1;
          end
          check($sformatf("inst%0d_req_ready", g), int'(req_ready), int'(e_rr));
          check($sformatf("inst%0d_ss_n", g), int'(ss_n), int'(e_ss));
          check($sformatf("inst%0d_sck", g), int'(sck), int'(e_sck));
          check($sformatf("inst%0d_mosi", g), int'(mosi), int'(e_mosi));
          check($sformatf("inst%0d_resp_valid", g), int'(resp_valid), int'(m_rv));
          check($sformatf("inst%0d_resp_data", g), int'(resp_data), int'(m_rd));
          // req_ready only falls on an accept.
          if (p_ready && !req_ready) begin
            gap      = ncyc - last_acc;
            last_acc = ncyc;
            acc_cyc  = ncyc;
            rises    = 0;
            mosi_seq = 16'h0;
          end
          if (sck && !p_sck) begin
            rises++;
            mosi_seq = {mosi_seq[14:0], mosi};
          end
          if (resp_valid) begin
            lat = ncyc - acc_cyc;
            check($sformatf("inst%0d_sck_rises", g), rises, mn);
          end
          p_ready = req_ready;
          p_sck   = sck;
        end
      end
    end
  end

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      if (g_inst[0].req_ready && g_inst[1].req_ready) begin
        ok = 1'b1;
        break;
      end
      req_data = 16'($urandom);
      req_len  = 4'($urandom);
      @(posedge clk);
      #1;
    end
    check("ready_timeout", int'(ok), 1);
  endtask

  task automatic xfer(input logic [15:0] d, input logic [3:0] l);
    wait_ready();
    req_valid = 1'b1;
    req_data  = d;
    req_len   = l;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble request fields while busy; the accepted values must stick.
    wait_ready();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic prev;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = 16'h0;
    req_len   = 4'h0;
    loop_mode = 1'b1;
    sl_word   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", int'(g_inst[0].req_ready), 1);
    check("reset_ss_n", int'(g_inst[0].ss_n), 1);
    check("reset_sck", int'(g_inst[0].sck), 0);
    check("reset_mosi", int'(g_inst[0].mosi), 1);
    check("reset_resp_valid", int'(g_inst[0].resp_valid), 0);
    check("reset_resp_data", int'(g_inst[0].resp_data), 0);
    rst_n = 1'b1;

    loop_mode = 1'b1;
    xfer(16'h00A5, 4'd8);
    check("loop_latency_div2", g_inst[0].lat, 34);
    check("loop_latency_div1", g_inst[1].lat, 17);
    check("loop_resp", int'(g_inst[0].resp_data), 16'h00A5);
    check("loop_mosi_seq", int'(g_inst[0].mosi_seq), 16'h00A5);

    loop_mode = 1'b0;
    sl_word   = 16'hFFFF;
    xfer(16'h1234, 4'd0);
    check("miso1_resp", int'(g_inst[0].resp_data), 16'hFFFF);
    check("miso1_latency", g_inst[0].lat, 66);
    sl_word = 16'h0000;
    xfer(16'hFFFF, 4'd3);
    check("miso0_resp", int'(g_inst[0].resp_data), 16'h0000);

    sl_word = 16'h003C;
    xfer(16'hC300, 4'd0);
    check("slave_resp_low", int'(g_inst[0].resp_data[7:0]), 8'h3C);

    // Continuous requests of one bit each.
    loop_mode = 1'b1;
    wait_ready();
    req_valid = 1'b1;
    req_len   = 4'd1;
    repeat (25) begin
      req_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_ready();
    @(negedge clk);
    #1;
    check("stream_gap_div1", g_inst[1].gap, 4);
    check("stream_gap_div2", g_inst[0].gap, 7);

    // Abort after the third sck rise.
    wait_ready();
    req_valid = 1'b1;
    req_data  = 16'h005A;
    req_len   = 4'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cnt  = 0;
    prev = 1'b0;
    for (int i = 0; i < 100 && cnt < 3; i++) begin
      @(posedge clk);
      #1;
      if (g_inst[0].sck && !prev) cnt++;
      prev = g_inst[0].sck;
    end
    check("abort_rises_seen", cnt, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_sck", int'(g_inst[0].sck), 0);
    check("abort_ss_n", int'(g_inst[0].ss_n), 1);
    check("abort_mosi", int'(g_inst[0].mosi), 1);
    check("abort_resp_valid", int'(g_inst[0].resp_valid), 0);
    repeat (12) @(posedge clk);
    #1;
    xfer(16'h0081, 4'd8);
    check("after_abort_resp", int'(g_inst[0].resp_data), 16'h0081);

    for (int k = 0; k < 24; k++) begin
      loop_mode = 1'($urandom);
      sl_word   = 16'($urandom);
      xfer(16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
